// File: rtl/melay_pkg.sv
// melay_pkg: definitions shared by the serial pattern transmitter and the
// Mealy sequence detector, so that the TX and RX sides and their benches agree.
//   tx_state_t         transmitter FSM encoding
//   DEF_WIDTH/CNT_W/GAP default transmitter parameters
//   DET_PATTERN(_LEN)   bit pattern the detector searches for, MSB first
package melay_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_GAP   = 1;

  localparam int             DET_PATTERN_LEN = 4;
  localparam logic [3:0]     DET_PATTERN     = 4'b1011;

  // The S_ prefix keeps the literals clear of the GAP parameter in the TX top.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } tx_state_t;

endpackage

// File: rtl/piso_shift.sv
// piso_shift: WIDTH-bit parallel-load, shift-left register, MSB out.
//   clk, rst  clock, async active-low reset (clears the register)
//   load      load din (has priority over shift)
//   shift     shift left by one, zero fill
//   din       parallel word
//   msb       current MSB of the register
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: accepts a WIDTH-bit word over valid/ready and sends it
// MSB-first on outp, max(load_reps,1) times back to back, followed by GAP idle
// cycles.
//   clk, rst    clock, async active-low reset
//   load_valid  word offered
//   load_ready  word can be accepted this cycle (decoded from state)
//   load_data   word to serialise
//   load_reps   repetition count, 0 behaves as 1
//   outp        serial bit (registered)
//   out_valid   outp carries a frame bit (registered)
//   last        final bit of the final repetition (registered)
//   busy        FSM not idle (registered)
//
// state   | meaning
// S_IDLE  | waiting for a word, load_ready=1
// S_SHIFT | sending bits; reloads the saved word between repetitions
// S_GAP   | idle cycles after a frame, load_ready=0
module seq_pattern_tx
  import melay_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int GAP   = DEF_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] load_reps,
  output logic             outp,
  output logic             out_valid,
  output logic             last,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = 4;

  tx_state_t        state, state_d;
  logic [BW-1:0]    bit_cnt, bit_cnt_d;
  logic [CNT_W-1:0] rep_left, rep_left_d, reps_m1;
  logic [GW-1:0]    gap_cnt, gap_cnt_d;
  logic [WIDTH-1:0] saved, piso_din;
  logic             load_en, shift_en, accept, ready_dec;

  assign reps_m1 = (load_reps == '0) ? '0 : load_reps - CNT_W'(1);

  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    rep_left_d = rep_left;
    gap_cnt_d  = gap_cnt;
    load_en    = 1'b0;
    shift_en   = 1'b0;
    accept     = 1'b0;
    ready_dec  = 1'b0;
    piso_din   = saved;

    case (state)
      S_IDLE: ready_dec = 1'b1;
      S_SHIFT: begin
        if (bit_cnt != '0) begin
          shift_en  = 1'b1;
          bit_cnt_d = bit_cnt - BW'(1);
        end else if (rep_left != '0) begin
          load_en    = 1'b1;
          bit_cnt_d  = BW'(WIDTH - 1);
          rep_left_d = rep_left - CNT_W'(1);
        end else begin
          // Shifting out the final bit leaves the register all zero, which
          // holds outp low through GAP and IDLE.
          shift_en = 1'b1;
          if (GAP > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = GW'(GAP - 1);
          end else begin
            state_d   = S_IDLE;
            ready_dec = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) state_d = S_IDLE;
        else               gap_cnt_d = gap_cnt - GW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Accept overrides the wind-down of the last bit when GAP==0, giving a
    // seamless back-to-back frame.
    if (ready_dec && load_valid) begin
      accept     = 1'b1;
      load_en    = 1'b1;
      shift_en   = 1'b0;
      piso_din   = load_data;
      bit_cnt_d  = BW'(WIDTH - 1);
      rep_left_d = reps_m1;
      state_d    = S_SHIFT;
    end
  end

  assign load_ready = rst & ready_dec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      rep_left  <= '0;
      gap_cnt   <= '0;
      saved     <= '0;
      out_valid <= 1'b0;
      last      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      rep_left  <= rep_left_d;
      gap_cnt   <= gap_cnt_d;
      if (accept) saved <= load_data;
      out_valid <= (state_d == S_SHIFT);
      last      <= (state_d == S_SHIFT) && (bit_cnt_d == '0) && (rep_left_d == '0);
      busy      <= (state_d != S_IDLE);
    end
  end

  piso_shift #(.WIDTH(WIDTH)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load_en),
    .shift (shift_en),
    .din   (piso_din),
    .msb   (outp)
  );

endmodule
